// File: rtl/bp_noc_link_merge.sv
// N-to-1 wormhole concentrator for ready-and NoC links: packet-atomic round-robin
// arbitration with header-encoded length, feeding a registered two-entry output buffer.
module bp_noc_link_merge #(
  parameter int flit_width_p = 64,
  parameter int num_in_p     = 4,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 0
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_in_p-1:0]              en_mask_i,
  input  logic [num_in_p*flit_width_p-1:0] data_i,
  input  logic [num_in_p-1:0]              v_i,
  output logic [num_in_p-1:0]              ready_and_o,
  output logic [flit_width_p-1:0]          data_o,
  output logic                             v_o,
  input  logic                             ready_and_i,
  output logic [num_in_p-1:0]              grant_o,
  output logic [31:0]                      pkt_count_o
);

  localparam int ptr_w_lp = $clog2(num_in_p);

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_busy = 1'b1
  } state_e;

  state_e                  state_r;
  logic [ptr_w_lp-1:0]     rr_ptr_r;
  logic [ptr_w_lp-1:0]     owner_idx_r;
  logic [len_width_p-1:0]  remaining_r;
  logic [31:0]             pkt_count_r;
  logic [flit_width_p-1:0] buf0_r;
  logic [flit_width_p-1:0] buf1_r;
  logic                    wr_ptr_r;
  logic                    rd_ptr_r;
  logic [1:0]              count_r;

  logic [num_in_p-1:0]     cand_s;
  logic                    win_found_s;
  logic [ptr_w_lp-1:0]     win_idx_s;
  logic [ptr_w_lp:0]       scan_idx_s;
  logic                    sel_valid_s;
  logic [ptr_w_lp-1:0]     sel_idx_s;
  logic [num_in_p-1:0]     ready_s;
  logic [num_in_p-1:0]     grant_s;
  logic [flit_width_p-1:0] sel_data_s;
  logic [len_width_p-1:0]  hdr_len_s;
  logic [ptr_w_lp-1:0]     next_ptr_s;
  logic                    full_s;
  logic                    enq_s;
  logic                    deq_s;

  assign full_s = (count_r == 2'd2);
  assign deq_s  = (count_r != 2'd0) & ready_and_i;

  // Round-robin scan: first enabled, valid input at or after rr_ptr, with wrap.
  always_comb begin
    cand_s      = v_i & en_mask_i;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    scan_idx_s  = '0;
    for (int k = 0; k < num_in_p; k++) begin
      scan_idx_s = {1'b0, rr_ptr_r} + (ptr_w_lp+1)'(k);
      if (scan_idx_s >= (ptr_w_lp+1)'(num_in_p)) begin
        scan_idx_s = scan_idx_s - (ptr_w_lp+1)'(num_in_p);
      end else begin
        scan_idx_s = scan_idx_s;
      end
      if (!win_found_s && cand_s[scan_idx_s[ptr_w_lp-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = scan_idx_s[ptr_w_lp-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Select the input being served and derive its ready and grant.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_idx_s   = '0;
    ready_s     = '0;
    grant_s     = '0;
    if (state_r == e_busy) begin
      sel_valid_s = 1'b1;
      sel_idx_s   = owner_idx_r;
    end else if (win_found_s) begin
      sel_valid_s = 1'b1;
      sel_idx_s   = win_idx_s;
    end else begin
      sel_valid_s = 1'b0;
    end
    if (sel_valid_s && !reset_i) begin
      grant_s[sel_idx_s] = 1'b1;
      ready_s[sel_idx_s] = ~full_s;
    end else begin
      grant_s = '0;
    end
  end

  // Flit mux from the selected input.
  always_comb begin
    sel_data_s = '0;
    for (int k = 0; k < num_in_p; k++) begin
      if (sel_idx_s == ptr_w_lp'(k)) begin
        sel_data_s = data_i[k*flit_width_p +: flit_width_p];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  assign hdr_len_s  = sel_data_s[len_offset_p +: len_width_p];
  assign next_ptr_s = (sel_idx_s == ptr_w_lp'(num_in_p-1)) ? '0 : sel_idx_s + ptr_w_lp'(1);
  assign enq_s      = |(v_i & ready_s);

  // Packet FSM: header arbitration, owner lock and body countdown.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= e_idle;
      rr_ptr_r    <= '0;
      owner_idx_r <= '0;
      remaining_r <= '0;
      pkt_count_r <= 32'd0;
    end else if (enq_s) begin
      case (state_r)
        e_idle: begin
          rr_ptr_r    <= next_ptr_s;
          owner_idx_r <= sel_idx_s;
          remaining_r <= hdr_len_s;
          if (hdr_len_s == '0) begin
            pkt_count_r <= pkt_count_r + 32'd1;
          end else begin
            state_r <= e_busy;
          end
        end
        e_busy: begin
          remaining_r <= remaining_r - len_width_p'(1);
          if (remaining_r == len_width_p'(1)) begin
            state_r     <= e_idle;
            pkt_count_r <= pkt_count_r + 32'd1;
          end else begin
            state_r <= e_busy;
          end
        end
        default: state_r <= e_idle;
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Two-entry output buffer; ready is computed from the pre-dequeue occupancy.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      buf0_r   <= '0;
      buf1_r   <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (enq_s) begin
        if (wr_ptr_r) begin
          buf1_r <= sel_data_s;
        end else begin
          buf0_r <= sel_data_s;
        end
        wr_ptr_r <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (deq_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign ready_and_o = ready_s;
  assign grant_o     = grant_s;
  assign pkt_count_o = pkt_count_r;
  assign v_o         = (count_r != 2'd0);
  assign data_o      = rd_ptr_r ? buf1_r : buf0_r;

endmodule

// File: tb/tb_bp_noc_link_merge.sv
// Bench for bp_noc_link_merge: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bp_noc_link_merge;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [3:0]  en_mask_i;
  logic [255:0] data_i;
  logic [3:0]  v_i;
  logic [3:0]  ready_and_o;
  logic [63:0] data_o;
  logic        v_o;
  logic        ready_and_i;
  logic [3:0]  grant_o;
  logic [31:0] pkt_count_o;

  bp_noc_link_merge #(.flit_width_p(64), .num_in_p(4), .len_width_p(4), .len_offset_p(0)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_mask_i(en_mask_i), .data_i(data_i), .v_i(v_i),
    .ready_and_o(ready_and_o), .data_o(data_o), .v_o(v_o), .ready_and_i(ready_and_i),
    .grant_o(grant_o), .pkt_count_o(pkt_count_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] src_q [4][$];
  logic [63:0] out_log [$];
  logic [3:0]  grant_log [$];

  // reference model state
  logic [63:0] m_buf [$];
  int          m_owner = -1;
  int          m_rem = 0;
  int          m_ptr = 0;
  int unsigned m_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input int src, input int pkt, input int seq, input int len);
    logic [63:0] f;
    f = 64'd0;
    f[63:56] = 8'(src);
    f[55:48] = 8'(pkt);
    f[47:40] = 8'(seq);
    f[3:0]   = 4'(len);
    return f;
  endfunction

  // input driver: pops flits the DUT took at the last edge, presents the next ones
  initial begin
    logic [3:0] hs;
    v_i = 4'd0;
    data_i = '0;
    forever begin
      @(negedge clk);
      hs = v_i & ready_and_o;
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          v_i[i] = 1'b1;
          data_i[i*64 +: 64] = src_q[i][0];
        end else begin
          v_i[i] = 1'b0;
          data_i[i*64 +: 64] = 64'd0;
        end
      end
    end
  end

  // per-cycle comparison against the model, then advance the model
  initial begin
    int sel;
    int len;
    logic [3:0] exp_ready;
    logic [3:0] exp_grant;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        check("rst_v_o", 64'(v_o), 64'd0);
        check("rst_data_o", data_o, 64'd0);
        check("rst_ready", 64'(ready_and_o), 64'd0);
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_pkt_count", 64'(pkt_count_o), 64'd0);
        m_buf.delete();
        m_owner = -1;
        m_rem = 0;
        m_ptr = 0;
        m_cnt = 0;
      end else begin
        sel = -1;
        if (m_owner >= 0) sel = m_owner;
        else begin
          for (int k = 0; k < 4; k++) begin
            if (sel < 0 && v_i[(m_ptr + k) % 4] && en_mask_i[(m_ptr + k) % 4]) sel = (m_ptr + k) % 4;
          end
        end
        exp_ready = 4'd0;
        exp_grant = 4'd0;
        if (sel >= 0) begin
          exp_grant[sel] = 1'b1;
          exp_ready[sel] = (m_buf.size() < 2);
        end
        check("ready_and_o", 64'(ready_and_o), 64'(exp_ready));
        check("grant_o", 64'(grant_o), 64'(exp_grant));
        check("v_o", 64'(v_o), 64'(m_buf.size() > 0));
        if (m_buf.size() > 0) check("data_o", data_o, m_buf[0]);
        check("pkt_count_o", 64'(pkt_count_o), 64'(m_cnt));
        if (v_o && ready_and_i) out_log.push_back(data_o);
        if (|(v_i & ready_and_o)) grant_log.push_back(grant_o);
        if (m_buf.size() > 0 && ready_and_i) void'(m_buf.pop_front());
        if (sel >= 0 && exp_ready[sel] && v_i[sel]) begin
          m_buf.push_back(data_i[sel*64 +: 64]);
          if (m_owner < 0) begin
            len = int'(data_i[sel*64 +: 4]);
            m_ptr = (sel + 1) % 4;
            if (len == 0) m_cnt++;
            else begin
              m_owner = sel;
              m_rem = len;
            end
          end else begin
            m_rem--;
            if (m_rem == 0) begin
              m_owner = -1;
              m_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs;
    out_log.delete();
    grant_log.delete();
  endtask

  task automatic wait_idle;
    int t;
    t = 0;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() > 0 ||
            v_i != 4'd0 || v_o) && t < 300) begin
      step(1);
      t++;
    end
    if (t >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: got timeout expected drain at %0t", $time);
    end
    step(1);
  endtask

  initial begin
    reset_i = 1'b1;
    en_mask_i = 4'hF;
    ready_and_i = 1'b1;
    step(3);
    reset_i = 1'b0;
    check("init_pkt_count", 64'(pkt_count_o), 64'd0);

    // fairness: every input offers two single-flit packets
    clear_logs();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 4; s++) src_q[s].push_back(mk(s, p, 0, 0));
    wait_idle();
    check("fair_count", 64'(out_log.size()), 64'd8);
    for (int n = 0; n < out_log.size(); n++) check("fair_src", 64'(out_log[n][63:56]), 64'(n % 4));
    check("fair_pkts", 64'(pkt_count_o), 64'd8);

    // single input, L=3
    clear_logs();
    for (int k = 0; k < 4; k++) src_q[0].push_back(mk(0, 9, k, (k == 0) ? 3 : k));
    wait_idle();
    check("single_count", 64'(out_log.size()), 64'd4);
    for (int k = 0; k < out_log.size(); k++) check("single_flit", out_log[k], mk(0, 9, k, (k == 0) ? 3 : k));
    check("single_pkts", 64'(pkt_count_o), 64'd9);

    // atomicity: input 1 L=2 against a waiting input 2
    clear_logs();
    src_q[1].push_back(mk(1, 1, 0, 2));
    src_q[1].push_back(mk(1, 1, 1, 1));
    src_q[1].push_back(mk(1, 1, 2, 2));
    src_q[2].push_back(mk(2, 2, 0, 0));
    wait_idle();
    check("atom_accepts", 64'(grant_log.size()), 64'd4);
    if (grant_log.size() == 4) begin
      check("atom_g0", 64'(grant_log[0]), 64'h2);
      check("atom_g1", 64'(grant_log[1]), 64'h2);
      check("atom_g2", 64'(grant_log[2]), 64'h2);
      check("atom_g3", 64'(grant_log[3]), 64'h4);
    end
    if (out_log.size() == 4) check("atom_last_src", 64'(out_log[3][63:56]), 64'd2);
    check("atom_pkts", 64'(pkt_count_o), 64'd11);

    // mask 1101: input 1 must never win
    clear_logs();
    en_mask_i = 4'b1101;
    for (int s = 0; s < 4; s++) src_q[s].push_back(mk(s, 3, 0, 0));
    step(8);
    check("mask_accepts", 64'(grant_log.size()), 64'd3);
    begin
      int hits;
      hits = 0;
      foreach (grant_log[n]) if (grant_log[n][1]) hits++;
      check("mask_in1_granted", 64'(hits), 64'd0);
    end
    check("mask_pkts", 64'(pkt_count_o), 64'd14);
    en_mask_i = 4'hF;
    wait_idle();
    check("mask_release_pkts", 64'(pkt_count_o), 64'd15);

    // mask cleared mid-packet on the owner
    clear_logs();
    for (int k = 0; k < 4; k++) src_q[0].push_back(mk(0, 4, k, (k == 0) ? 3 : 0));
    step(2);
    en_mask_i = 4'b1110;
    wait_idle();
    check("midmask_count", 64'(out_log.size()), 64'd4);
    for (int k = 0; k < out_log.size(); k++) check("midmask_flit", out_log[k], mk(0, 4, k, (k == 0) ? 3 : 0));
    check("midmask_pkts", 64'(pkt_count_o), 64'd16);
    en_mask_i = 4'hF;

    // backpressure during an L=7 packet
    clear_logs();
    for (int k = 0; k < 8; k++) src_q[2].push_back(mk(2, 6, k, (k == 0) ? 7 : k));
    step(1);
    ready_and_i = 1'b0;
    step(5);
    check("bp_accepted", 64'(grant_log.size()), 64'd2);
    check("bp_ready", 64'(ready_and_o), 64'd0);
    check("bp_v_o", 64'(v_o), 64'd1);
    ready_and_i = 1'b1;
    wait_idle();
    check("bp_count", 64'(out_log.size()), 64'd8);
    for (int k = 0; k < out_log.size(); k++) check("bp_flit", out_log[k], mk(2, 6, k, (k == 0) ? 7 : k));
    check("bp_pkts", 64'(pkt_count_o), 64'd17);

    // reset in the middle of a 5-flit packet
    clear_logs();
    for (int k = 0; k < 5; k++) src_q[1].push_back(mk(1, 7, k, (k == 0) ? 4 : 0));
    begin
      int t;
      t = 0;
      while (out_log.size() < 2 && t < 50) begin
        step(1);
        t++;
      end
      check("rstmid_reached", 64'(out_log.size() >= 2), 64'd1);
    end
    reset_i = 1'b1;
    for (int s = 0; s < 4; s++) src_q[s].delete();
    #1;
    check("rstmid_v_o", 64'(v_o), 64'd0);
    check("rstmid_grant", 64'(grant_o), 64'd0);
    check("rstmid_pkts", 64'(pkt_count_o), 64'd0);
    step(2);
    reset_i = 1'b0;
    clear_logs();
    src_q[3].push_back(mk(3, 8, 0, 0));
    wait_idle();
    check("post_rst_accepts", 64'(grant_log.size()), 64'd1);
    if (grant_log.size() == 1) check("post_rst_grant", 64'(grant_log[0]), 64'h8);
    if (out_log.size() == 1) check("post_rst_flit", out_log[0], mk(3, 8, 0, 0));
    check("post_rst_pkts", 64'(pkt_count_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
